// File: rtl/seven_segment_counter_mux.sv
// N-digit BCD up/down counter with prescaled tick, synchronous load and a
// time-multiplexed seven-segment drive with optional common-anode inversion.
// Ports: clk, rst (sync, active-low), en, up_down, load, load_value in;
//        segments {g..a}, dp, digit_sel (one-hot), count (BCD), tick, wrap out.
module seven_segment_counter_mux #(
   parameter int MAX_COUNT     = 10_000_000,
   parameter int NUM_DIGITS    = 2,
   parameter int REFRESH_COUNT = 1000,
   parameter int COMMON_ANODE  = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up_down,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    tick,
   output logic                    wrap
);

   localparam int PW = $clog2(MAX_COUNT);
   localparam int RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic INV = (COMMON_ANODE != 0);

   logic [PW-1:0]             presc;
   logic [RW-1:0]             refresh;
   logic [IW-1:0]             idx;
   logic [IW-1:0]             idx_nxt;
   logic                      fire;
   logic                      term;
   logic [4*NUM_DIGITS-1:0]   cnt_nxt;
   logic [4*NUM_DIGITS-1:0]   lv_clamp;
   logic                      wrap_nxt;
   logic [3:0]                nib;
   logic [NUM_DIGITS-1:0]     sel_raw;

   function automatic logic [6:0] dec(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign fire = en && (presc == PW'(MAX_COUNT - 1));
   assign term = (refresh == RW'(REFRESH_COUNT - 1));

   // Ripple carry/borrow through the digits; a carry out of the top
   // digit means the whole counter wrapped.
   always_comb begin
      logic       c;
      logic [3:0] d;
      cnt_nxt = count;
      c       = 1'b1;
      d       = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = count[4*i +: 4];
         if (c) begin
            if (up_down) begin
               if (d >= 4'd9) begin
                  cnt_nxt[4*i +: 4] = 4'd0;
               end else begin
                  cnt_nxt[4*i +: 4] = d + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  cnt_nxt[4*i +: 4] = 4'd9;
               end else begin
                  cnt_nxt[4*i +: 4] = d - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      wrap_nxt = c;
   end

   always_comb begin
      lv_clamp = load_value;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (load_value[4*i +: 4] > 4'd9) begin
            lv_clamp[4*i +: 4] = 4'd9;
         end
      end
   end

   always_comb begin
      idx_nxt = idx;
      if (term && NUM_DIGITS > 1) begin
         if (idx == IW'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
         end else begin
            idx_nxt = idx + 1'b1;
         end
      end
   end

   // Display path is built from the next digit index so that digit_sel
   // and segments are registered on the same edge and always agree.
   assign nib     = count[{idx_nxt, 2'b00} +: 4];
   assign sel_raw = NUM_DIGITS'(1) << idx_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc     <= '0;
         count     <= '0;
         refresh   <= '0;
         idx       <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         dp        <= INV;
         digit_sel <= NUM_DIGITS'(1) ^ {NUM_DIGITS{INV}};
         segments  <= 7'h3F ^ {7{INV}};
      end else begin
         if (load) begin
            presc <= '0;
         end else if (en) begin
            presc <= fire ? '0 : presc + 1'b1;
         end

         if (load) begin
            count <= lv_clamp;
            tick  <= 1'b0;
            wrap  <= 1'b0;
         end else if (fire) begin
            count <= cnt_nxt;
            tick  <= 1'b1;
            wrap  <= wrap_nxt;
         end else begin
            tick  <= 1'b0;
            wrap  <= 1'b0;
         end

         refresh   <= term ? '0 : refresh + 1'b1;
         idx       <= idx_nxt;
         digit_sel <= sel_raw ^ {NUM_DIGITS{INV}};
         segments  <= dec(nib) ^ {7{INV}};
         dp        <= ((idx_nxt == '0) &&
                       (presc < PW'(MAX_COUNT / 2))) ^ INV;
      end
   end

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Scoreboard bench: stimulus queues expected tick results, a negedge
// monitor pops and compares them whenever the counter ticks.
module tb_seven_segment_counter_mux;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up_down;
   logic       load;
   logic [7:0] load_value;
   logic [6:0] segments;
   logic       dp;
   logic [1:0] digit_sel;
   logic [7:0] count;
   logic       tick;
   logic       wrap;
   logic [6:0] segments_ca;
   logic       dp_ca;
   logic [1:0] digit_sel_ca;
   logic [7:0] count_ca;
   logic       tick_ca;
   logic       wrap_ca;

   typedef struct {
      logic [7:0] cnt;
      logic       wr;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seven_segment_counter_mux #(
      .MAX_COUNT(4), .NUM_DIGITS(2), .REFRESH_COUNT(2), .COMMON_ANODE(0)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
      .load_value(load_value), .segments(segments), .dp(dp),
      .digit_sel(digit_sel), .count(count), .tick(tick), .wrap(wrap)
   );

   seven_segment_counter_mux #(
      .MAX_COUNT(4), .NUM_DIGITS(2), .REFRESH_COUNT(2), .COMMON_ANODE(1)
   ) dut_ca (
      .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
      .load_value(load_value), .segments(segments_ca), .dp(dp_ca),
      .digit_sel(digit_sel_ca), .count(count_ca), .tick(tick_ca),
      .wrap(wrap_ca)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tick === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_tick: got count %0h expected none",
                     count);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("tick_count", 32'(count), 32'(e.cnt));
            chk("tick_wrap", 32'(wrap), 32'(e.wr));
            chk("tick_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic push(input logic [7:0] c, input logic w, input int t);
      exp_t e;
      e.cnt = c;
      e.wr  = w;
      e.cyc = t;
      q.push_back(e);
   endtask

   task automatic load_val(input logic [7:0] v, output int lc);
      load       = 1'b1;
      load_value = v;
      @(negedge clk);
      load = 1'b0;
      lc   = cyc;
   endtask

   initial begin
      int c0;
      int lc;
      int k;
      logic [1:0] esel;
      rst = 1'b0; en = 1'b0; up_down = 1'b1;
      load = 1'b0; load_value = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 32'h00);
      chk("rst_sel", 32'(digit_sel), 32'h1);
      chk("rst_seg", 32'(segments), 32'h3F);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_ca_sel", 32'(digit_sel_ca), 32'h2);
      chk("rst_ca_seg", 32'(segments_ca), 32'h40);
      chk("rst_ca_dp", 32'(dp_ca), 32'h1);

      // count up from reset
      rst = 1'b1; en = 1'b1; up_down = 1'b1;
      c0 = cyc;
      push(8'h01, 1'b0, c0 + 4);
      push(8'h02, 1'b0, c0 + 8);
      push(8'h03, 1'b0, c0 + 12);
      repeat (5) @(negedge clk);
      chk("up1_sel", 32'(digit_sel), 32'h1);
      chk("up1_seg", 32'(segments), 32'h06);
      repeat (4) @(negedge clk);
      chk("up2_sel", 32'(digit_sel), 32'h1);
      chk("up2_seg", 32'(segments), 32'h5B);
      repeat (4) @(negedge clk);
      chk("up3_sel", 32'(digit_sel), 32'h1);
      chk("up3_seg", 32'(segments), 32'h4F);

      // BCD carry and full wrap upward
      load_val(8'h09, lc);
      push(8'h10, 1'b0, lc + 4);
      repeat (4) @(negedge clk);
      load_val(8'h99, lc);
      push(8'h00, 1'b1, lc + 4);
      repeat (4) @(negedge clk);

      // downward wrap then plain borrow
      up_down = 1'b0;
      load_val(8'h00, lc);
      push(8'h99, 1'b1, lc + 4);
      push(8'h98, 1'b0, lc + 8);
      repeat (8) @(negedge clk);

      // load lands on the fire edge; nibble F clamps to 9
      repeat (3) @(negedge clk);
      load_val(8'h3F, lc);
      chk("ld_count", 32'(count), 32'h39);
      chk("ld_tick", 32'(tick), 32'h0);
      push(8'h38, 1'b0, lc + 4);
      repeat (4) @(negedge clk);

      // enable low: count frozen, display keeps multiplexing
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         k = cyc - c0;
         esel = ((k / 2) % 2 != 0) ? 2'b10 : 2'b01;
         chk("hold_count", 32'(count), 32'h38);
         chk("hold_tick", 32'(tick), 32'h0);
         chk("mux_sel", 32'(digit_sel), 32'(esel));
         chk("mux_seg", 32'(segments),
             (esel == 2'b01) ? 32'h7F : 32'h4F);
         chk("mux_dp", 32'(dp), (esel == 2'b01) ? 32'h1 : 32'h0);
      end

      // reset in the middle of operation
      en = 1'b1; up_down = 1'b1;
      load_val(8'h57, lc);
      chk("pre_rst_ca_count", 32'(count_ca), 32'h57);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ca_count", 32'(count_ca), 32'h00);
      chk("mid_rst_ca_sel", 32'(digit_sel_ca), 32'h2);
      chk("mid_rst_ca_seg", 32'(segments_ca), 32'h40);
      chk("mid_rst_ca_tick", 32'(tick_ca), 32'h0);
      chk("mid_rst_ca_wrap", 32'(wrap_ca), 32'h0);
      chk("mid_rst_count", 32'(count), 32'h00);
      chk("mid_rst_seg", 32'(segments), 32'h3F);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("ticks_outstanding", 32'(q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
